// File: rtl/jelly_denorm_pkg.sv
// Shared constant helpers for the denorm arithmetic blocks (width math used by
// the converters, adders and multipliers of the denorm chain).
package jelly_denorm_pkg;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << result) < value) begin
            result = result + 1;
         end
      end
      return result;
   endfunction

   // Wide enough that biased exponent arithmetic plus a full normalization shift never wraps.
   function automatic int exp_calc_width(input int denorm_exp_width, input int float_exp_width,
                                         input int fixed_width);
      int base;
      base = (denorm_exp_width > float_exp_width) ? denorm_exp_width : float_exp_width;
      return base + clog2(fixed_width) + 2;
   endfunction

endpackage

// File: rtl/jelly_leading_one_detect.sv
// Combinational count of leading zeros above the most significant set bit.
// An all-zero input reports clz = WIDTH and raises zero.
module jelly_leading_one_detect
   import jelly_denorm_pkg::*;
#(
   parameter  int WIDTH     = 33,
   localparam int CLZ_WIDTH = clog2(WIDTH + 1)
)
(
   input  logic [WIDTH-1:0]     mag,
   output logic [CLZ_WIDTH-1:0] clz,
   output logic                 zero
);

   // Ascending scan: the last set bit seen is the highest one, so it wins.
   always_comb begin
      clz  = CLZ_WIDTH'(WIDTH);
      zero = (mag == '0);
      for (int i = 0; i < WIDTH; i++) begin
         if (mag[i]) begin
            clz = CLZ_WIDTH'(WIDTH - 1 - i);
         end
      end
   end

endmodule

// File: rtl/jelly_denorm_to_float.sv
// Renormalizes a denorm value (biased exponent + signed fixed mantissa) into a packed
// sign/exponent/fraction float through a four-stage valid/ready pipeline.
module jelly_denorm_to_float
   import jelly_denorm_pkg::*;
#(
   parameter  int DENORM_EXP_WIDTH   = 8,
   parameter  int DENORM_EXP_OFFSET  = (1 << (DENORM_EXP_WIDTH - 1)) - 1,
   parameter  int DENORM_INT_WIDTH   = 25,
   parameter  int DENORM_FRAC_WIDTH  = 8,
   parameter  int DENORM_FIXED_WIDTH = DENORM_INT_WIDTH + DENORM_FRAC_WIDTH,
   parameter  int FLOAT_EXP_WIDTH    = 8,
   parameter  int FLOAT_EXP_OFFSET   = (1 << (FLOAT_EXP_WIDTH - 1)) - 1,
   parameter  int FLOAT_FRAC_WIDTH   = 23,
   parameter  int FLOAT_WIDTH        = 1 + FLOAT_EXP_WIDTH + FLOAT_FRAC_WIDTH,
   parameter  int USER_WIDTH         = 0,
   parameter  int MASTER_IN_REGS     = 1,
   parameter  int MASTER_OUT_REGS    = 1,
   localparam int USER_BITS          = (USER_WIDTH > 0) ? USER_WIDTH : 1
)
(
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 cke,
   input  logic [USER_BITS-1:0]                 s_user,
   input  logic [DENORM_EXP_WIDTH-1:0]          s_denorm_exp,
   input  logic signed [DENORM_FIXED_WIDTH-1:0] s_denorm_fixed,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   output logic [USER_BITS-1:0]                 m_user,
   output logic [FLOAT_WIDTH-1:0]               m_float,
   output logic                                 m_valid,
   input  logic                                 m_ready
);

   localparam int W     = DENORM_FIXED_WIDTH;
   localparam int E     = FLOAT_EXP_WIDTH;
   localparam int F     = FLOAT_FRAC_WIDTH;
   localparam int CLZ_W = clog2(W + 1);
   localparam int EXP_W = exp_calc_width(DENORM_EXP_WIDTH, E, W);
   localparam logic signed [EXP_W-1:0] EXP_INF = EXP_W'((1 << E) - 1);
   localparam logic signed [EXP_W-1:0] EXP_MIN = '0;

   logic                        st0_valid_q, st0_valid_d, st0_sign_q, st0_sign_d;
   logic [W-1:0]                st0_mag_q, st0_mag_d;
   logic [DENORM_EXP_WIDTH-1:0] st0_exp_q, st0_exp_d;
   logic [USER_BITS-1:0]        st0_user_q, st0_user_d;

   logic                        st1_valid_q, st1_valid_d, st1_sign_q, st1_sign_d;
   logic                        st1_zero_q, st1_zero_d;
   logic [W-1:0]                st1_mag_q, st1_mag_d;
   logic [DENORM_EXP_WIDTH-1:0] st1_exp_q, st1_exp_d;
   logic [CLZ_W-1:0]            st1_clz_q, st1_clz_d;
   logic [USER_BITS-1:0]        st1_user_q, st1_user_d;

   logic                        st2_valid_q, st2_valid_d, st2_sign_q, st2_sign_d;
   logic                        st2_zero_q, st2_zero_d;
   logic [F-1:0]                st2_frac_q, st2_frac_d;
   logic signed [EXP_W-1:0]     st2_exp_q, st2_exp_d;
   logic [USER_BITS-1:0]        st2_user_q, st2_user_d;

   logic                        st3_valid_q, st3_valid_d, st4_valid_q, st4_valid_d;
   logic                        skid_valid_q, skid_valid_d;
   logic [FLOAT_WIDTH-1:0]      st3_float_q, st3_float_d, st4_float_q, st4_float_d;
   logic [FLOAT_WIDTH-1:0]      skid_float_q, skid_float_d;
   logic [USER_BITS-1:0]        st3_user_q, st3_user_d, st4_user_q, st4_user_d;
   logic [USER_BITS-1:0]        skid_user_q, skid_user_d;

   logic [CLZ_W-1:0]            lod_clz;
   logic                        lod_zero;
   logic [FLOAT_WIDTH-1:0]      pack_float;
   logic                        ready0, ready1, ready2, ready3, ready4, ready_out;
   logic                        tail_valid;
   logic [FLOAT_WIDTH-1:0]      tail_float;
   logic [USER_BITS-1:0]        tail_user;

   jelly_leading_one_detect #(
      .WIDTH (W)
   ) u_lod (
      .mag  (st0_mag_q),
      .clz  (lod_clz),
      .zero (lod_zero)
   );

   // With the input register option the ready seen by the pipeline comes from the
   // skid register, so m_ready never reaches s_ready combinationally.
   assign ready_out  = (MASTER_IN_REGS != 0) ? !skid_valid_q : m_ready;
   assign ready4     = (MASTER_OUT_REGS != 0) ? (!st4_valid_q || ready_out) : ready_out;
   assign ready3     = !st3_valid_q || ready4;
   assign ready2     = !st2_valid_q || ready3;
   assign ready1     = !st1_valid_q || ready2;
   assign ready0     = !st0_valid_q || ready1;
   assign s_ready    = ready0;

   assign tail_valid = (MASTER_OUT_REGS != 0) ? st4_valid_q : st3_valid_q;
   assign tail_float = (MASTER_OUT_REGS != 0) ? st4_float_q : st3_float_q;
   assign tail_user  = (MASTER_OUT_REGS != 0) ? st4_user_q  : st3_user_q;

   assign m_valid    = skid_valid_q || tail_valid;
   assign m_float    = skid_valid_q ? skid_float_q : tail_float;
   assign m_user     = skid_valid_q ? skid_user_q  : tail_user;

   // Classification of the normalized value: zero, underflow, overflow, normal.
   always_comb begin
      pack_float = '0;
      if (st2_zero_q) begin
         pack_float = '0;
      end else if (st2_exp_q <= EXP_MIN) begin
         pack_float = {st2_sign_q, {E{1'b0}}, {F{1'b0}}};
      end else if (st2_exp_q >= EXP_INF) begin
         pack_float = {st2_sign_q, {E{1'b1}}, {F{1'b0}}};
      end else begin
         pack_float = {st2_sign_q, st2_exp_q[E-1:0], st2_frac_q};
      end
   end

   always_comb begin
      st0_valid_d = st0_valid_q;  st0_sign_d = st0_sign_q;  st0_mag_d = st0_mag_q;
      st0_exp_d   = st0_exp_q;    st0_user_d = st0_user_q;
      st1_valid_d = st1_valid_q;  st1_sign_d = st1_sign_q;  st1_zero_d = st1_zero_q;
      st1_mag_d   = st1_mag_q;    st1_exp_d  = st1_exp_q;   st1_clz_d  = st1_clz_q;
      st1_user_d  = st1_user_q;
      st2_valid_d = st2_valid_q;  st2_sign_d = st2_sign_q;  st2_zero_d = st2_zero_q;
      st2_frac_d  = st2_frac_q;   st2_exp_d  = st2_exp_q;   st2_user_d = st2_user_q;
      st3_valid_d = st3_valid_q;  st3_float_d = st3_float_q; st3_user_d = st3_user_q;
      st4_valid_d = st4_valid_q;  st4_float_d = st4_float_q; st4_user_d = st4_user_q;
      skid_valid_d = skid_valid_q; skid_float_d = skid_float_q; skid_user_d = skid_user_q;

      if (cke && ready0) begin
         st0_valid_d = s_valid;
         st0_sign_d  = s_denorm_fixed[W-1];
         st0_mag_d   = s_denorm_fixed[W-1] ? W'(-s_denorm_fixed) : W'(s_denorm_fixed);
         st0_exp_d   = s_denorm_exp;
         st0_user_d  = s_user;
      end
      if (cke && ready1) begin
         st1_valid_d = st0_valid_q;
         st1_sign_d  = st0_sign_q;
         st1_zero_d  = lod_zero;
         st1_mag_d   = st0_mag_q;
         st1_exp_d   = st0_exp_q;
         st1_clz_d   = lod_clz;
         st1_user_d  = st0_user_q;
      end
      // The fraction is the F bits directly below the leading one; short mantissas zero-pad.
      if (cke && ready2) begin
         st2_valid_d = st1_valid_q;
         st2_sign_d  = st1_sign_q;
         st2_zero_d  = st1_zero_q;
         st2_frac_d  = F'({st1_mag_q << st1_clz_q, {F{1'b0}}} >> (W - 1));
         st2_exp_d   = EXP_W'(st1_exp_q) + EXP_W'(W - 1 + FLOAT_EXP_OFFSET) - EXP_W'(st1_clz_q)
                     - EXP_W'(DENORM_EXP_OFFSET + DENORM_FRAC_WIDTH);
         st2_user_d  = st1_user_q;
      end
      if (cke && ready3) begin
         st3_valid_d = st2_valid_q;
         st3_float_d = pack_float;
         st3_user_d  = st2_user_q;
      end
      if (cke && ready4 && (MASTER_OUT_REGS != 0)) begin
         st4_valid_d = st3_valid_q;
         st4_float_d = st3_float_q;
         st4_user_d  = st3_user_q;
      end
      if (cke) begin
         if (skid_valid_q) begin
            if (m_ready) begin
               skid_valid_d = 1'b0;
            end
         end else if ((MASTER_IN_REGS != 0) && tail_valid && !m_ready) begin
            skid_valid_d = 1'b1;
            skid_float_d = tail_float;
            skid_user_d  = tail_user;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st0_valid_q <= 1'b0;  st0_sign_q <= 1'b0;  st0_mag_q <= '0;
         st0_exp_q   <= '0;    st0_user_q <= '0;
         st1_valid_q <= 1'b0;  st1_sign_q <= 1'b0;  st1_zero_q <= 1'b0;
         st1_mag_q   <= '0;    st1_exp_q  <= '0;    st1_clz_q  <= '0;
         st1_user_q  <= '0;
         st2_valid_q <= 1'b0;  st2_sign_q <= 1'b0;  st2_zero_q <= 1'b0;
         st2_frac_q  <= '0;    st2_exp_q  <= '0;    st2_user_q <= '0;
         st3_valid_q <= 1'b0;  st3_float_q <= '0;   st3_user_q <= '0;
         st4_valid_q <= 1'b0;  st4_float_q <= '0;   st4_user_q <= '0;
         skid_valid_q <= 1'b0; skid_float_q <= '0;  skid_user_q <= '0;
      end else begin
         st0_valid_q <= st0_valid_d;  st0_sign_q <= st0_sign_d;  st0_mag_q <= st0_mag_d;
         st0_exp_q   <= st0_exp_d;    st0_user_q <= st0_user_d;
         st1_valid_q <= st1_valid_d;  st1_sign_q <= st1_sign_d;  st1_zero_q <= st1_zero_d;
         st1_mag_q   <= st1_mag_d;    st1_exp_q  <= st1_exp_d;   st1_clz_q  <= st1_clz_d;
         st1_user_q  <= st1_user_d;
         st2_valid_q <= st2_valid_d;  st2_sign_q <= st2_sign_d;  st2_zero_q <= st2_zero_d;
         st2_frac_q  <= st2_frac_d;   st2_exp_q  <= st2_exp_d;   st2_user_q <= st2_user_d;
         st3_valid_q <= st3_valid_d;  st3_float_q <= st3_float_d; st3_user_q <= st3_user_d;
         st4_valid_q <= st4_valid_d;  st4_float_q <= st4_float_d; st4_user_q <= st4_user_d;
         skid_valid_q <= skid_valid_d; skid_float_q <= skid_float_d; skid_user_q <= skid_user_d;
      end
   end

endmodule

// File: tb/tb_jelly_denorm_to_float.sv
// Scoreboard bench for jelly_denorm_to_float: directed vectors with hand-computed
// floats, backpressure, clock-enable freeze and asynchronous reset mid-stream.
module tb_jelly_denorm_to_float;

   typedef struct packed {
      logic [31:0] floatVal;
      logic [7:0]  userVal;
   } scoreItem_t;

   logic               clock;
   logic               reset;
   logic               cke;
   logic [7:0]         sUser;
   logic [7:0]         sExp;
   logic signed [32:0] sFixed;
   logic               sValid;
   logic               sReady;
   logic [7:0]         mUser;
   logic [31:0]        mFloat;
   logic               mValid;
   logic               mReady;

   int                 assertCount = 0;
   int                 failCount   = 0;
   bit                 streamDone  = 0;
   scoreItem_t         sbQueue[$];

   logic [7:0]         vecExp   [16] = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127,
                                        8'd130, 8'd120, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127};
   logic signed [32:0] vecFixed [16] = '{33'sd256, 33'sd512, 33'sd768, -33'sd256, 33'sd128, 33'sd64,
                                        33'sd1280, -33'sd640, 33'sd256, 33'sd256, 33'sd2560, -33'sd4096,
                                        33'sd1, 33'sd3, 33'sd25600, -33'sd32};
   logic [31:0]        vecFloat [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'hBF800000,
                                        32'h3F000000, 32'h3E800000, 32'h40A00000, 32'hC0200000,
                                        32'h41000000, 32'h3C000000, 32'h41200000, 32'hC1800000,
                                        32'h3B800000, 32'h3C400000, 32'h42C80000, 32'hBE000000};

   jelly_denorm_to_float #(
      .USER_WIDTH (8)
   ) dut (
      .clk            (clock),
      .reset          (reset),
      .cke            (cke),
      .s_user         (sUser),
      .s_denorm_exp   (sExp),
      .s_denorm_fixed (sFixed),
      .s_valid        (sValid),
      .s_ready        (sReady),
      .m_user         (mUser),
      .m_float        (mFloat),
      .m_valid        (mValid),
      .m_ready        (mReady)
   );

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Watchdog so a stuck handshake can never hang the run.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] required);
      assertCount++;
      if (actual !== required) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
      end
   endtask

   // Pops the oldest expected transaction and compares it against the presented output.
   task automatic checkOutput();
      scoreItem_t item;
      if (sbQueue.size() == 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL unexpected_output: got float %h user %h, required no output", mFloat, mUser);
      end else begin
         item = sbQueue.pop_front();
         checkValue("m_float", mFloat, item.floatVal);
         checkValue("m_user", {24'h0, mUser}, {24'h0, item.userVal});
      end
   endtask

   // Monitor: an output transfer completes at the next edge when valid, ready and cke are all high.
   initial begin
      forever begin
         @(negedge clock);
         if (!reset && cke && mValid && mReady) begin
            checkOutput();
         end
      end
   end

   // Drives one input transaction; the expected result enters the scoreboard once it is accepted.
   task automatic applyStimulus(input logic [7:0] expIn, input logic signed [32:0] fixedIn,
                                input logic [7:0] userIn, input logic [31:0] expected);
      bit accepted;
      accepted = 1'b0;
      sExp   = expIn;
      sFixed = fixedIn;
      sUser  = userIn;
      sValid = 1'b1;
      for (int i = 0; i < 300 && !accepted; i++) begin
         @(negedge clock);
         if (sReady && cke && !reset) begin
            sbQueue.push_back('{floatVal: expected, userVal: userIn});
            accepted = 1'b1;
         end
         @(posedge clock);
         #1;
      end
      sValid = 1'b0;
      if (!accepted) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL accept_timeout: got no s_ready, required acceptance of user %h", userIn);
      end
   endtask

   task automatic waitDrain(input int maxCycles);
      for (int i = 0; i < maxCycles && sbQueue.size() != 0; i++) begin
         @(posedge clock);
         #1;
      end
      if (sbQueue.size() != 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL drain_timeout: got %0d pending, required 0", sbQueue.size());
         sbQueue.delete();
      end
   endtask

   initial begin
      reset  = 1'b1;
      cke    = 1'b1;
      sValid = 1'b0;
      sUser  = '0;
      sExp   = '0;
      sFixed = '0;
      mReady = 1'b1;
      #12;
      checkValue("reset_m_valid", 32'(mValid), 32'h0);
      checkValue("reset_m_float", mFloat, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      checkValue("reset_s_ready", 32'(sReady), 32'h1);

      $display("[TB] basic values");
      applyStimulus(8'd127, 33'sd256, 8'h01, 32'h3F800000);
      applyStimulus(8'd127, -33'sd384, 8'h02, 32'hBFC00000);
      applyStimulus(8'd200, 33'sd0, 8'h03, 32'h00000000);
      applyStimulus(8'd127, 33'h1_0000_0000, 8'h04, 32'hCB800000);
      applyStimulus(8'd250, 33'sd2147483648, 8'h05, 32'h7F800000);
      applyStimulus(8'd1, 33'sd1, 8'h06, 32'h00000000);
      applyStimulus(8'd1, -33'sd1, 8'h07, 32'h80000000);
      applyStimulus(8'd127, 33'sd4294967295, 8'h08, 32'h4B7FFFFF);
      applyStimulus(8'd255, 33'sd256, 8'h09, 32'h7F800000);
      applyStimulus(8'd254, 33'sd256, 8'h0A, 32'h7F000000);
      applyStimulus(8'd1, 33'sd256, 8'h0B, 32'h00800000);
      applyStimulus(8'd0, -33'sd256, 8'h0C, 32'h80000000);
      waitDrain(100);

      $display("[TB] streaming with backpressure");
      streamDone = 1'b0;
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               applyStimulus(vecExp[i], vecFixed[i], 8'h40 + 8'(i), vecFloat[i]);
            end
            streamDone = 1'b1;
         end
         begin
            for (int c = 0; c < 4; c++) begin
               @(posedge clock);
               #1;
               mReady = 1'($urandom_range(0, 1));
            end
            @(posedge clock);
            #1;
            mReady = 1'b0;
            repeat (6) @(posedge clock);
            @(negedge clock);
            checkValue("stall_s_ready", 32'(sReady), 32'h0);
            while (!streamDone) begin
               @(posedge clock);
               #1;
               mReady = 1'($urandom_range(0, 1));
            end
            mReady = 1'b1;
         end
      join
      mReady = 1'b1;
      waitDrain(200);

      $display("[TB] clock enable freeze");
      applyStimulus(8'd127, 33'sd512, 8'h81, 32'h40000000);
      applyStimulus(8'd127, -33'sd768, 8'h82, 32'hC0400000);
      applyStimulus(8'd128, 33'sd256, 8'h83, 32'h40000000);
      cke = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkValue("cke_hold_m_valid", 32'(mValid), 32'h0);
      end
      @(posedge clock);
      #1;
      cke = 1'b1;
      waitDrain(100);

      $display("[TB] asynchronous reset mid-stream");
      mReady = 1'b0;
      applyStimulus(8'd127, 33'sd256, 8'hA1, 32'h3F800000);
      applyStimulus(8'd127, 33'sd512, 8'hA2, 32'h40000000);
      applyStimulus(8'd127, 33'sd768, 8'hA3, 32'h40400000);
      repeat (6) @(posedge clock);
      @(negedge clock);
      checkValue("pre_reset_m_valid", 32'(mValid), 32'h1);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      checkValue("async_reset_m_valid", 32'(mValid), 32'h0);
      checkValue("async_reset_m_float", mFloat, 32'h0);
      sbQueue.delete();
      repeat (2) @(posedge clock);
      #3;
      reset = 1'b0;
      @(posedge clock);
      #1;
      mReady = 1'b1;
      applyStimulus(8'd129, -33'sd256, 8'hB1, 32'hC0800000);
      waitDrain(100);
      repeat (10) @(posedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
